// File: rtl/neuron_mac.sv
// neuron_mac: serial fixed-point multiply-accumulate neuron.
//
// Computes z = sum(x_i * w_i) + bias over N_INPUTS pairs, all operands signed
// Q(WIDTH-FRAC-1).FRAC. The result is rounded to nearest (ties toward +inf) and
// saturated back to WIDTH bits for the downstream activation block.
//
// Ports:
//   clk        clock, all state changes on its rising edge
//   rst_n      synchronous active-low reset
//   in_valid   x/w pair presented
//   in_ready   pair accepted this cycle (ACCUM state only)
//   x, w       signed input activation and weight
//   bias       signed bias, held stable for the whole evaluation
//   out_valid  z__value is valid (OUT state)
//   out_ready  downstream accepts z__value
//   z__value   saturated pre-activation value
module neuron_mac #(
    parameter int unsigned N_INPUTS  = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned FRAC      = 4,
    parameter int unsigned ACC_WIDTH = 21
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] w,
    input  logic signed [WIDTH-1:0] bias,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] z__value
);

    // Counter holds values 0..N_INPUTS so it never wraps before being cleared.
    localparam int unsigned CntW = $clog2(N_INPUTS + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(N_INPUTS - 1);

    localparam logic [1:0] StAccum = 2'd0;
    localparam logic [1:0] StBias  = 2'd1;
    localparam logic [1:0] StOut   = 2'd2;

    localparam logic signed [ACC_WIDTH-1:0] RoundK = ACC_WIDTH'(1) << (FRAC - 1);
    localparam logic signed [ACC_WIDTH-1:0] ZMax   = ACC_WIDTH'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] ZMin   = ~ZMax;

    logic [1:0]                  state_q, state_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [WIDTH-1:0]     z_q, z_d;

    logic signed [2*WIDTH-1:0]   prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] bias_term;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic                        accept;

    assign in_ready  = rst_n && (state_q == StAccum);
    assign out_valid = (state_q == StOut);
    assign z__value  = z_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        prod      = x * w;
        prod_ext  = {{(ACC_WIDTH - 2 * WIDTH){prod[2*WIDTH-1]}}, prod};
        // Bias is aligned to the product's 2*FRAC fractional bits.
        bias_term = {{(ACC_WIDTH - WIDTH - FRAC){bias[WIDTH-1]}}, bias, {FRAC{1'b0}}};
        sum       = acc_q + bias_term + RoundK;
        // Arithmetic shift after adding half an LSB rounds ties toward +inf.
        shifted   = sum >>> FRAC;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        z_d     = z_q;
        case (state_q)
            StAccum: begin
                if (accept) begin
                    acc_d = acc_q + prod_ext;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_d = StBias;
                    end
                end
            end
            StBias: begin
                if (shifted > ZMax) begin
                    z_d = ZMax[WIDTH-1:0];
                end else if (shifted < ZMin) begin
                    z_d = ZMin[WIDTH-1:0];
                end else begin
                    z_d = shifted[WIDTH-1:0];
                end
                state_d = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StAccum;
                end
            end
            default: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = StAccum;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StAccum;
            cnt_q   <= '0;
            acc_q   <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
module tb_neuron_mac;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] x = 8'h00;
    logic [7:0] w = 8'h00;
    logic [7:0] bias = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] z;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    neuron_mac dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .w        (w),
        .bias     (bias),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .z__value (z)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Reference: exact integer sum, round half up, saturate to 8 bits.
    function automatic logic [7:0] model(input logic [31:0] xs, input logic [31:0] ws,
                                         input logic [7:0] b);
        int acc;
        int xi;
        int wi;
        int bi;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            xi = int'($signed(xs[8*i +: 8]));
            wi = int'($signed(ws[8*i +: 8]));
            acc = acc + xi * wi;
        end
        bi = int'($signed(b));
        acc = acc + bi * 16 + 8;
        acc = acc >>> 4;
        if (acc > 127) acc = 127;
        if (acc < -128) acc = -128;
        return acc[7:0];
    endfunction

    // Presents one pair starting just after a rising edge; returns just after the
    // edge that accepted it (plus gap idle cycles with garbage on x/w).
    task automatic send_pair(input logic [7:0] xv, input logic [7:0] wv, input int gap,
                             input string name);
        int t;
        t = 0;
        in_valid = 1'b1;
        x = xv;
        w = wv;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_accept in_ready=%0b out_valid=%0b required 1/0",
                     name, in_ready, out_valid);
        end
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x = 8'($urandom);
        w = 8'($urandom);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Full evaluation: scoreboard push, pairs, latency check, optional
    // backpressure, pop/compare, output handshake. Ends just after that edge.
    task automatic run_eval(input logic [31:0] xs, input logic [31:0] ws, input logic [7:0] b,
                            input int gap, input int hold, input string name);
        logic [7:0] zexp;
        int t;
        exp_q.push_back(model(xs, ws, b));
        bias = b;
        out_ready = (hold == 0);
        for (int i = 0; i < 4; i++) begin
            send_pair(xs[8*i +: 8], ws[8*i +: 8], (i < 3) ? gap : 0, name);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_bias_cycle out_valid=%0b in_ready=%0b required 0/0",
                     name, out_valid, in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_latency out_valid=%0b required 1", name, out_valid);
        end
        t = 0;
        while (out_valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        zexp = exp_q.pop_front();
        checks++;
        if (z !== zexp) begin
            failures++;
            $display("FAIL %s_z z__value=%02h required %02h", name, z, zexp);
        end
        if (hold > 0) begin
            in_valid = 1'b1;
            for (int h = 0; h < hold; h++) begin
                x = 8'($urandom);
                w = 8'($urandom);
                @(posedge clk);
                #1;
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b1 || z !== zexp || in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_hold%0d out_valid=%0b z=%02h in_ready=%0b required 1/%02h/0",
                             name, h, out_valid, z, in_ready, zexp);
                end
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || z !== 8'h00 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_state out_valid=%0b z=%02h in_ready=%0b required 0/00/0",
                     out_valid, z, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release in_ready=%0b out_valid=%0b required 1/0",
                     in_ready, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        run_eval(32'h10101010, 32'h10101010, 8'h00, 0, 0, "basic");
    endtask

    task automatic test_saturation();
        run_eval(32'h7F7F7F7F, 32'h7F7F7F7F, 8'h00, 0, 0, "sat_pos");
        run_eval(32'h80808080, 32'h7F7F7F7F, 8'h00, 0, 0, "sat_neg");
    endtask

    task automatic test_rounding();
        run_eval(32'h00000001, 32'h00000008, 8'h00, 0, 0, "round_up");
        run_eval(32'h00000001, 32'h00000007, 8'h00, 0, 0, "round_down");
        run_eval(32'h000000FF, 32'h00000008, 8'h00, 0, 0, "round_tie_neg");
    endtask

    task automatic test_bias_only();
        run_eval(32'h00000000, $urandom, 8'h08, 0, 0, "bias_pos");
        run_eval(32'h00000000, $urandom, 8'hF0, 0, 0, "bias_neg");
    endtask

    task automatic test_back_to_back();
        run_eval(32'h20F01008, 32'h10203040, 8'h11, 0, 5, "backpressure");
        run_eval(32'h10101010, 32'h10101010, 8'h00, 0, 0, "after_release");
    endtask

    task automatic test_gaps();
        run_eval(32'h3A05E1C4, 32'h17F2098D, 8'hFB, 2, 0, "gapped");
        run_eval(32'h3A05E1C4, 32'h17F2098D, 8'hFB, 0, 0, "gapfree");
    endtask

    task automatic test_reset_mid();
        // Leaves z__value nonzero so the reset clear is visible.
        run_eval(32'h00000000, 32'h00000000, 8'hE0, 0, 0, "pre_abort");
        send_pair(8'h40, 8'h40, 0, "abort");
        send_pair(8'h40, 8'h40, 0, "abort");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || z !== 8'h00) begin
            failures++;
            $display("FAIL abort_reset out_valid=%0b z=%02h required 0/00", out_valid, z);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_eval(32'h10101010, 32'h10101010, 8'h00, 0, 0, "post_abort");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_eval($urandom, $urandom, 8'($urandom), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 2)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_rounding();
        test_bias_only();
        test_back_to_back();
        test_gaps();
        test_reset_mid();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover size=%0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Fixed-point serial multiply-accumulate neuron that computes a layer neuron's pre-activation value z = Σ(xᵢ·wᵢ) + b from a stream of input/weight pairs. It sits directly upstream of the layer's LUT-plus-interpolation activation function and drives that block's 8-bit signed `z__value` input. All data uses signed Q3.4: 8 bits, 4 fractional bits. The activation block splits `z__value` into bits [7:4] for the LUT address and bits [3:0] for the interpolation remainder, so the output format is fixed.

## Interface
- `N_INPUTS`, 4: pairs per neuron evaluation; allowed range 1–16.
- `WIDTH`, 8: data width of x, w, bias and z (signed).
- `FRAC`, 4: fractional bits of every WIDTH-bit operand.
- `ACC_WIDTH`, 21: accumulator width; must be ≥ 2·WIDTH + ceil(log2(N_INPUTS)) + 1.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `in_valid` input 1: an x/w pair is presented.
- `in_ready` output 1: the block accepts a pair this cycle.
- `x` input WIDTH signed: input activation, Q3.4.
- `w` input WIDTH signed: weight, Q3.4.
- `bias` input WIDTH signed: neuron bias, Q3.4. Must be stable from the first pair accepted until the output handshake completes.
- `out_valid` output 1: `z__value` is valid.
- `out_ready` input 1: downstream accepts `z__value`.
- `z__value` output WIDTH signed: saturated pre-activation value, Q3.4.

## Operation
- FSM states:
  - ACCUM: `in_ready`=1. Each cycle with `in_valid`&&`in_ready`, add sign-extended x·w (2·WIDTH bits, Q.8) to acc and increment cnt. When the pair with cnt==N_INPUTS−1 is accepted, go to BIAS.
  - BIAS: `in_ready`=0. Compute acc + (sign-extend(bias) << FRAC), add rounding constant 1<<(FRAC−1), arithmetic-shift right by FRAC, saturate to [−128, 127]. Register the result into `z__value`, then go to OUT.
  - OUT: `out_valid`=1, `in_ready`=0. On `out_ready`=1, clear acc and cnt and go to ACCUM.
- Rounding is round-to-nearest with ties toward +∞. No intermediate saturation is applied; the accumulator width guarantees no overflow.
- Saturation limits are 0x7F and 0x80.
- `in_valid` without `in_ready` has no effect. x and w are sampled only on an accepted handshake.
- Backpressure: while in OUT with `out_ready`=0, `out_valid` and `z__value` hold stable.
- Reset values: state=ACCUM, acc=0, cnt=0, `out_valid`=0, `z__value`=0x00, `in_ready`=0 during the reset cycle and 1 from the first cycle after `rst_n` rises.
- Reset asserted mid-accumulation or in OUT discards the partial sum or the pending result. No output handshake occurs for that evaluation.

## Timing
- Throughput: 1 pair per cycle while in ACCUM.
- Latency: the last pair is accepted at edge k. BIAS runs in cycle k+1, and `out_valid`=1 from the cycle after edge k+1. Zero-wait handshake completes at edge k+2.
- Minimum period per evaluation: N_INPUTS + 2 cycles with `out_ready` tied high.
- The first pair of the next evaluation can be accepted in the cycle after the output handshake edge. Input and output handshakes never overlap.
- `z__value` changes only at the BIAS→OUT edge or on reset.

## Test plan
- Four pairs (x=0x10, w=0x10), bias=0x00, `out_ready`=1 → `out_valid` 2 cycles after the last pair; `z__value`=0x40 (4.0).
- Four pairs (0x7F, 0x7F) → `z__value`=0x7F. Four pairs (0x80, 0x7F) → `z__value`=0x80. Checks positive and negative saturation.
- Rounding: one pair (0x01, 0x08) plus three (0x00, 0x00) → `z__value`=0x01. Same with w=0x07 → 0x00. Same with x=0xFF, w=0x08 → 0x00 (tie toward +∞).
- Bias only: all x=0, bias=0x08 → `z__value`=0x08. All x=0, bias=0xF0 → `z__value`=0xF0.
- Backpressure: hold `out_ready`=0 for 5 cycles → `out_valid` and `z__value` stable and `in_ready`=0 throughout. Release → handshake completes, and the next pair is accepted on the following cycle. Toggling `in_valid` with gaps between pairs gives the same result as a gap-free stream.
- Reset: drop `rst_n` after 2 of 4 pairs → the next cycle shows `out_valid`=0 and `z__value`=0x00. A following full evaluation of four pairs (0x10, 0x10) yields 0x40 with no residue from the aborted evaluation.
